// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the iteration-counter width helper.
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic int div_cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/cla_sub_stage.sv
// Combinational W-bit subtractor a - b computed as a + ~b + 1, with every
// carry expanded into generate/propagate look-ahead terms.
module cla_sub_stage #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W-1:0] g_s;
  logic [W-1:0] p_s;
  logic [W:0]   c_s;

  // Carry into bit i, flattened: g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]c0, with c0 = 1
  function automatic logic lookahead_carry(input logic [W-1:0] g,
                                           input logic [W-1:0] p,
                                           input int i);
    logic c;
    logic run;
    c   = 1'b0;
    run = 1'b1;
    for (int j = i - 1; j >= 0; j--) begin
      c   = c | (run & g[j]);
      run = run & p[j];
    end
    return c | run;
  endfunction

  assign g_s    = a & ~b;
  assign p_s    = a ^ ~b;
  assign c_s[0] = 1'b1;

  for (genvar i = 1; i <= W; i++) begin : g_carry
    assign c_s[i] = lookahead_carry(g_s, p_s, i);
  end

  assign diff   = p_s ^ c_s[W-1:0];
  assign borrow = ~c_s[W];

endmodule

// File: rtl/seq_div_4bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Define DIV_ZERO_CHECK_EN to short-cut divide-by-zero and raise div_by_zero.
module seq_div_4bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CW       = div_cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   t_s;
  logic             borrow_s;
  logic             no_borrow_s;

  assign r_shift_s = {r_q, q_q[WIDTH-1]};

  cla_sub_stage #(.W(WIDTH + 1)) u_sub (
    .a      (r_shift_s),
    .b      ({1'b0, v_q}),
    .diff   (t_s),
    .borrow (borrow_s)
  );

  // The stored remainder stays below the divisor, so a borrow-out and a set guard bit both mean "restore"
  assign no_borrow_s = ~borrow_s & ~t_s[WIDTH];

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_q, dbz_d;
`endif

  // Next-state, datapath iteration and registered-output updates
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    v_d     = v_q;
    r_d     = r_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_CHECK_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          q_d   = dividend;
          v_d   = divisor;
          r_d   = {WIDTH{1'b0}};
          cnt_d = CNT_INIT;
`ifdef DIV_ZERO_CHECK_EN
          if (divisor == {WIDTH{1'b0}}) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            quot_d  = {WIDTH{1'b1}};
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
          end
`else
          state_d = ST_CALC;
          busy_d  = 1'b1;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        q_d = {q_q[WIDTH-2:0], no_borrow_s};
        r_d = no_borrow_s ? t_s[WIDTH-1:0] : r_shift_s[WIDTH-1:0];
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          quot_d  = q_d;
          rem_d   = r_d;
`ifdef DIV_ZERO_CHECK_EN
          dbz_d   = 1'b0;
`endif
        end else begin
          cnt_d  = cnt_q - CNT_ONE;
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      q_q     <= {WIDTH{1'b0}};
      v_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      v_q     <= v_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  // Divide-by-zero flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbz_q <= 1'b0;
    end else begin
      dbz_q <= dbz_d;
    end
  end

  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_seq_div_4bit.sv
// Self-checking bench for seq_div_4bit: arithmetic reference model with a
// per-cycle compare process, directed literal cases and a randomized-gap sweep.
module tb_seq_div_4bit;

  localparam int W   = 4;
  localparam int LAT = 4;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int           m_left;
  logic [W-1:0] m_a, m_b;
  logic         exp_busy, exp_done, exp_z;
  logic [W-1:0] exp_q, exp_r;

  always #5 clk = ~clk;

  seq_div_4bit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_finish();
    exp_done = 1'b1;
    exp_z    = 1'b0;
    if (m_b == 4'd0) begin
      exp_q = 4'd15;
      exp_r = m_a;
    end else begin
      exp_q = m_a / m_b;
      exp_r = m_a % m_b;
    end
  endtask

  // Model: an accepted divide finishes LAT edges later (or at once for a checked zero divisor)
  initial begin
    m_left = 0; m_a = 4'd0; m_b = 4'd0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_z = 1'b0; exp_q = 4'd0; exp_r = 4'd0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (rst_n !== 1'b1) begin
        m_left = 0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_z = 1'b0; exp_q = 4'd0; exp_r = 4'd0;
      end else begin
        exp_done = 1'b0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) model_finish();
        end else if (start === 1'b1) begin
          m_a = dividend;
          m_b = divisor;
          if (ZCHK && divisor == 4'd0) begin
            model_finish();
            exp_z = 1'b1;
          end else begin
            m_left = LAT;
          end
        end
        exp_busy = (m_left > 0);
      end
    end
  end

  // Compare DUT against the model on every falling edge
  initial begin
    forever begin
      @(negedge clk);
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      if (exp_done) begin
        check("quotient", quotient, exp_q);
        check("remainder", remainder, exp_r);
        check("div_by_zero", div_by_zero, exp_z);
        if (m_b != 4'd0) begin
          check("invariant", int'(quotient) * int'(m_b) + int'(remainder), m_a);
          check("rem_lt_div", remainder < m_b, 1);
        end
      end
    end
  end

  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) lat = -1;
  endtask

  // Caller is at a falling edge; returns at the falling edge where done is seen
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, lat);
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           lat;
    logic [W-1:0] q, r;
    logic         z;
    logic [W-1:0] ta [3], tb [3], tq [3], tr [3];
    ta[0] = 4'd15; tb[0] = 4'd1; tq[0] = 4'd15; tr[0] = 4'd0;
    ta[1] = 4'd3;  tb[1] = 4'd7; tq[1] = 4'd0;  tr[1] = 4'd3;
    ta[2] = 4'd0;  tb[2] = 4'd5; tq[2] = 4'd0;  tr[2] = 4'd0;

    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(4'd13, 4'd4, lat, q, r, z);
    check("t1_latency", lat, LAT);
    check("t1_q", q, 3);
    check("t1_r", r, 1);
    check("t1_dbz", z, 0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      do_op(ta[i], tb[i], lat, q, r, z);
      check("t2_latency", lat, LAT);
      check("t2_q", q, tq[i]);
      check("t2_r", r, tr[i]);
    end

    @(negedge clk);
    do_op(4'd9, 4'd0, lat, q, r, z);
    check("t3_latency", lat, ZCHK ? 0 : LAT);
    check("t3_q", q, 15);
    check("t3_r", r, 9);
    check("t3_dbz", z, ZCHK);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    wait_done(2, lat);
    check("t4_latency", lat, LAT);
    check("t4_q", quotient, 3);
    check("t4_r", remainder, 1);

    // start in the DONE cycle is accepted
    start = 1'b1; dividend = 4'd7; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    check("t4_b2b_busy", busy, 1);
    wait_done(0, lat);
    check("t4_b2b_latency", lat, LAT);
    check("t4_b2b_q", quotient, 3);
    check("t4_b2b_r", remainder, 1);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_q", quotient, 0);
    check("t5_r", remainder, 0);
    check("t5_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_done", done, 0);
    end
    do_op(4'd10, 4'd3, lat, q, r, z);
    check("t5_latency", lat, LAT);
    check("t5_q_after", q, 3);
    check("t5_r_after", r, 1);

    // all operand pairs with random gaps
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_op(W'(a), W'(b), lat, q, r, z);
        check("sweep_latency", lat, (ZCHK && b == 0) ? 0 : LAT);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
